// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the serial pattern transmitter: state codes and their
// width, also used by the board top to decode the state onto the LEDs.
package sequence_generator_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] STATE_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] STATE_SHIFT = 3'd1;
  localparam logic [STATE_W-1:0] STATE_GAP   = 3'd2;
  localparam logic [STATE_W-1:0] STATE_DONE  = 3'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_SHIFT = STATE_SHIFT,
    ST_GAP   = STATE_GAP,
    ST_DONE  = STATE_DONE
  } state_e;

endpackage

// File: rtl/sequence_generator_if.sv
// Request and serial-stream signals of the pattern transmitter. The master
// side supplies the pattern and start strobe; the slave side is the generator.
interface sequence_generator_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4
);
  import sequence_generator_pkg::*;

  logic                 start;
  logic [MAX_LEN-1:0]   pattern;
  logic [LEN_W-1:0]     len;
  logic [REP_W-1:0]     reps;
  logic                 w_out;
  logic                 w_valid;
  logic                 busy;
  logic                 done;
  logic [STATE_W-1:0]   state;

  modport master (
    output start, pattern, len, reps,
    input  w_out, w_valid, busy, done, state
  );

  modport slave (
    input  start, pattern, len, reps,
    output w_out, w_valid, busy, done, state
  );

endinterface

// File: rtl/sequence_generator_piso_shift.sv
// Parallel-load, MSB-out shift register. A load places the low len_i bits of
// data_i at the top of the register so the first bit to send is always the MSB.
module piso_shift #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  int               shiftAmt;

  // Left-justify the load value; load wins over shift when both are requested
  always_comb begin
    shiftAmt = 0;
    if (int'(len_i) < WIDTH) begin
      shiftAmt = WIDTH - int'(len_i);
    end
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i << shiftAmt;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // Shift register storage with synchronous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated a
// programmed number of times with forced-zero gaps, then pulses done.
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_LEN = 2
) (
  input logic                 clock,
  input logic                 reset,
  sequence_generator_if.slave bus
);

  localparam int GAP_W = (GAP_LEN < 1) ? 1 : $clog2(GAP_LEN + 1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   bitCnt_q, bitCnt_d;
  logic [LEN_W-1:0]   effLen_q, effLen_d;
  logic [REP_W-1:0]   repCnt_q, repCnt_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;

  logic               clampedLen_unused;
  logic [LEN_W-1:0]   clampedLen;
  logic               shiftLoad;
  logic               shiftEn;
  logic [MAX_LEN-1:0] loadData;
  logic [LEN_W-1:0]   loadLen;
  logic               shiftMsb;

  assign clampedLen_unused = 1'b0;
  assign clampedLen = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;

  piso_shift #(
    .WIDTH (MAX_LEN),
    .LEN_W (LEN_W)
  ) u_piso (
    .clock   (clock),
    .reset   (reset),
    .load_i  (shiftLoad),
    .shift_i (shiftEn),
    .data_i  (loadData),
    .len_i   (loadLen),
    .msb_o   (shiftMsb)
  );

  // Next-state, counter and shift-register control decode
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    effLen_d  = effLen_q;
    repCnt_d  = repCnt_q;
    pattern_d = pattern_q;
    gapCnt_d  = gapCnt_q;
    shiftLoad = 1'b0;
    shiftEn   = 1'b0;
    loadData  = pattern_q;
    loadLen   = effLen_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pattern_d = bus.pattern;
          effLen_d  = clampedLen;
          repCnt_d  = bus.reps;
          if (clampedLen == '0 || bus.reps == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_SHIFT;
            bitCnt_d  = clampedLen;
            shiftLoad = 1'b1;
            loadData  = bus.pattern;
            loadLen   = clampedLen;
          end
        end
      end

      ST_SHIFT: begin
        shiftEn  = 1'b1;
        bitCnt_d = bitCnt_q - LEN_W'(1);
        if (bitCnt_q == LEN_W'(1)) begin
          if (repCnt_q > REP_W'(1)) begin
            repCnt_d = repCnt_q - REP_W'(1);
            if (GAP_LEN == 0) begin
              shiftLoad = 1'b1;
              bitCnt_d  = effLen_q;
            end else begin
              state_d  = ST_GAP;
              gapCnt_d = GAP_W'(GAP_LEN);
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_GAP: begin
        if (gapCnt_q == GAP_W'(1)) begin
          state_d   = ST_SHIFT;
          shiftLoad = 1'b1;
          bitCnt_d  = effLen_q;
          gapCnt_d  = '0;
        end else begin
          gapCnt_d = gapCnt_q - GAP_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset abandons any transfer without a done pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bitCnt_q  <= '0;
      effLen_q  <= '0;
      repCnt_q  <= '0;
      pattern_q <= '0;
      gapCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      effLen_q  <= effLen_d;
      repCnt_q  <= repCnt_d;
      pattern_q <= pattern_d;
      gapCnt_q  <= gapCnt_d;
    end
  end

  assign bus.w_valid = (state_q == ST_SHIFT);
  assign bus.w_out   = (state_q == ST_SHIFT) & shiftMsb & ~clampedLen_unused;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.state   = state_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: each scenario queues the cycle-by-
// cycle output it expects and compares it against the DUT on the falling edge.
module tb_sequence_generator;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int REP_W   = 4;
  localparam int GAP_LEN = 2;

  logic clock;
  logic reset;

  sequence_generator_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

  sequence_generator #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .REP_W   (REP_W),
    .GAP_LEN (GAP_LEN)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Observed record: {w_out, w_valid, busy, done, state[2:0]}
  wire [6:0] obs = {bus.w_out, bus.w_valid, bus.busy, bus.done, bus.state};

  logic [6:0] expQ[$];
  logic [6:0] expRec;
  int checks = 0;
  int errors = 0;

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Guard against a stuck simulation
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed %b", obs);
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected trace of one accepted request, from the cycle after accept through one idle cycle
  function automatic void pushExpected(logic [MAX_LEN-1:0] pat, logic [LEN_W-1:0] ln,
                                       logic [REP_W-1:0] rp);
    int effLen;
    int repN;
    effLen = (int'(ln) > MAX_LEN) ? MAX_LEN : int'(ln);
    repN   = int'(rp);
    if (effLen != 0 && repN != 0) begin
      for (int r = 0; r < repN; r++) begin
        for (int i = 0; i < effLen; i++) begin
          expQ.push_back({pat[effLen-1-i], 1'b1, 1'b1, 1'b0, 3'd1});
        end
        if (r < repN - 1) begin
          for (int g = 0; g < GAP_LEN; g++) begin
            expQ.push_back({1'b0, 1'b0, 1'b1, 1'b0, 3'd2});
          end
        end
      end
    end
    expQ.push_back({1'b0, 1'b0, 1'b1, 1'b1, 3'd3});
    expQ.push_back(7'd0);
  endfunction

  // Called just after a falling edge: present a request for exactly one rising edge
  task automatic applyStimulus(logic [MAX_LEN-1:0] pat, logic [LEN_W-1:0] ln,
                               logic [REP_W-1:0] rp);
    bus.pattern = pat;
    bus.len     = ln;
    bus.reps    = rp;
    bus.start   = 1'b1;
    pushExpected(pat, ln, rp);
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.reps    = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (obs !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: observed %b, expected %b", obs, 7'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== 7'd0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: observed %b, expected %b", obs, 7'd0);
    end
  endtask

  task automatic test_single();
    int cycle;
    applyStimulus(8'b0000_1101, 4'd4, 4'd1);
    cycle = 1;
    while (expQ.size() > 0) begin
      @(negedge clock);
      expRec = expQ.pop_front();
      checks++;
      if (obs !== expRec) begin
        errors++;
        $display("[TB] FAIL single cycle %0d: observed %b, expected %b", cycle, obs, expRec);
      end
      cycle++;
    end
  endtask

  task automatic test_repeat_gap();
    int cycle;
    applyStimulus(8'h0F, 4'd4, 4'd3);
    cycle = 1;
    while (expQ.size() > 0) begin
      @(negedge clock);
      expRec = expQ.pop_front();
      checks++;
      if (obs !== expRec) begin
        errors++;
        $display("[TB] FAIL repeat_gap cycle %0d: observed %b, expected %b", cycle, obs, expRec);
      end
      cycle++;
    end
  endtask

  task automatic test_zero();
    int cycle;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) applyStimulus(8'hFF, 4'd0, 4'd3);
      else        applyStimulus(8'hFF, 4'd4, 4'd0);
      cycle = 1;
      while (expQ.size() > 0) begin
        @(negedge clock);
        expRec = expQ.pop_front();
        checks++;
        if (obs !== expRec) begin
          errors++;
          $display("[TB] FAIL zero_case%0d cycle %0d: observed %b, expected %b",
                   t, cycle, obs, expRec);
        end
        cycle++;
      end
    end
  endtask

  task automatic test_reset_midflight();
    int cycle;
    applyStimulus(8'b0010_1101, 4'd6, 4'd1);
    for (cycle = 1; cycle <= 2; cycle++) begin
      @(negedge clock);
      expRec = expQ.pop_front();
      checks++;
      if (obs !== expRec) begin
        errors++;
        $display("[TB] FAIL midflight cycle %0d: observed %b, expected %b", cycle, obs, expRec);
      end
    end
    expQ.delete();
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== 7'd0) begin
      errors++;
      $display("[TB] FAIL midflight_reset: observed %b, expected %b", obs, 7'd0);
    end
    applyStimulus(8'b0000_0101, 4'd3, 4'd1);
    cycle = 1;
    while (expQ.size() > 0) begin
      @(negedge clock);
      expRec = expQ.pop_front();
      checks++;
      if (obs !== expRec) begin
        errors++;
        $display("[TB] FAIL restart cycle %0d: observed %b, expected %b", cycle, obs, expRec);
      end
      cycle++;
    end
  endtask

  task automatic test_ignore_and_clamp();
    int cycle;
    applyStimulus(8'hF9, 4'd4, 4'd1);
    expQ.push_back(7'd0);
    expQ.push_back(7'd0);
    cycle = 1;
    while (expQ.size() > 0) begin
      @(negedge clock);
      expRec = expQ.pop_front();
      checks++;
      if (obs !== expRec) begin
        errors++;
        $display("[TB] FAIL ignore_start cycle %0d: observed %b, expected %b", cycle, obs, expRec);
      end
      bus.start = (cycle == 2 || cycle == 5);
      if (cycle == 3) begin
        bus.pattern = 8'h00;
        bus.len     = 4'd2;
        bus.reps    = 4'd5;
      end
      cycle++;
    end
    bus.start = 1'b0;
    applyStimulus(8'b1100_1011, 4'd9, 4'd1);
    cycle = 1;
    while (expQ.size() > 0) begin
      @(negedge clock);
      expRec = expQ.pop_front();
      checks++;
      if (obs !== expRec) begin
        errors++;
        $display("[TB] FAIL clamp cycle %0d: observed %b, expected %b", cycle, obs, expRec);
      end
      if (cycle == 2) begin
        bus.pattern = 8'h3C;
        bus.len     = 4'd1;
      end
      cycle++;
    end
  endtask

  task automatic test_back_to_back();
    int cycle;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   ln;
    logic [REP_W-1:0]   rp;
    for (int t = 0; t < 4; t++) begin
      pat = MAX_LEN'($urandom);
      ln  = LEN_W'($urandom_range(1, MAX_LEN));
      rp  = REP_W'($urandom_range(1, 3));
      applyStimulus(pat, ln, rp);
      cycle = 1;
      while (expQ.size() > 0) begin
        @(negedge clock);
        expRec = expQ.pop_front();
        checks++;
        if (obs !== expRec) begin
          errors++;
          $display("[TB] FAIL back_to_back%0d cycle %0d: observed %b, expected %b",
                   t, cycle, obs, expRec);
        end
        cycle++;
      end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_single();
    test_repeat_gap();
    test_zero();
    test_reset_midflight();
    test_ignore_and_clamp();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
